mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
//
// PURPOSE
// - Shares one single-port memory instance between two requesters (port 0 = instruction fetch, port 1 = data/load-store).
// - Accepts one request at a time through a req/ack handshake, sequences the memory access and returns read data with a one-cycle ack pulse.
// - Sits between the core/test sequencers and the memory block; drives its mem_addr, i_mem_data, mem_rw and samples o_mem_data.
//
// PARAMETERS
// - ADDR_W   32  address width; byte address, forwarded unchanged to memory.
// - DATA_W   32  data width for read and write data.
// - READ_LAT 1   clock cycles from address presented to memory until o_mem_data is valid (1..4).
//
// PORTS
// - clk        in   1       system clock; every register is clocked on its rising edge.
// - resetn     in   1       synchronous reset, active-low.
// - req0       in   1       port 0 request; held high with addr0/rw0 stable until ack0.
// - rw0        in   1       port 0 direction: 1 = read, 0 = write.
// - addr0      in   ADDR_W  port 0 address.
// - wdata0     in   DATA_W  port 0 write data.
// - ack0       out  1       one-cycle pulse: port 0 access complete.
// - req1/rw1/addr1/wdata1/ack1  port 1 equivalents, same widths and rules.
// - rdata      out  DATA_W  read data; valid only in the cycle where ack0 or ack1 is high.
// - busy       out  1       high when state != IDLE.
// - mem_addr   out  ADDR_W  to memory mem_addr.
// - mem_wdata  out  DATA_W  to memory i_mem_data.
// - mem_rw     out  1       to memory mem_rw (1 = read, 0 = write).
// - mem_rdata  in   DATA_W  from memory o_mem_data.
//
// BEHAVIOUR
// - Reset (resetn low at a clk edge):
//   - state = IDLE; ack0 = ack1 = 0; rdata = 0; busy = 0; mem_addr = 0; mem_wdata = 0; mem_rw = 1.
//   - Round-robin pointer last = 1, so port 0 wins the first tie.
// - FSM IDLE -> ACCESS -> WAIT -> RESP -> IDLE. All outputs are registered.
// - IDLE: if any req is high, grant the winner and latch its addr/wdata/rw onto mem_* -> ACCESS. With no req, mem_rw stays 1.
// - Arbitration:
//   - Exactly one req high: that port wins.
//   - Both high: the port != last wins; last updates to the granted port.
// - ACCESS (1 cycle): mem_* held.
//   - Write: go to RESP; then mem_rw returns to 1.
//   - Read: go to WAIT with lat_cnt = READ_LAT-1. If READ_LAT = 1, WAIT lasts 1 cycle.
// - WAIT: decrement lat_cnt. At 0, register mem_rdata into rdata -> RESP.
// - RESP (1 cycle): ack of the granted port = 1, the other ack = 0 -> IDLE.
//   - The next grant is evaluated in the IDLE cycle after RESP; a requester drops req in the cycle after ack.
// - Latency, request first seen high in IDLE at cycle 0:
//   - Read ack at cycle 2+READ_LAT (cycle 3 by default).
//   - Write ack at cycle 2.
//   - Back-to-back reads on one port: one per 3+READ_LAT cycles.
// - rdata holds its last value until the next read; it is not updated by writes.
// - Only one ack is ever high per cycle. ack is never asserted without a preceding grant.
// - Changes to req/addr/rw of the granted port after the grant are ignored until ack.
// - Address arithmetic: none; no wrap or alignment checks (memory handles them).
// - Reset mid-access: the access is abandoned, no ack is issued, mem_rw is forced to 1 in the reset cycle.
//   - A write in ACCESS when reset is sampled: whether the memory wrote is undefined.
//
// CONFIGURATION
// - MEM_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins a tie; last is not used.
//   - Port 1 may starve while req0 is held continuously.
// - Not defined (default): round-robin as above; neither port waits more than one foreign access.
//
// TESTING
// - Memory model: mem[i] = 32'h1000_0000 + i, READ_LAT = 1.
// - Single read: req0 rw0=1 addr0=0x08 at cycle 0 -> ack0 high only at cycle 3, rdata = 0x1000_0002, busy high in cycles 1-3.
// - Tie: req0 addr 0x00 and req1 addr 0x04 at cycle 0 -> ack0 cycle 3 (rdata 0x1000_0000), ack1 cycle 7 (rdata 0x1000_0001).
//   - Repeat the tie -> port 1 served first.
// - Write then read: port 1 rw1=0 addr 0x10 wdata 0xDEAD_BEEF -> ack1 at cycle 2, mem_rw=0 during cycle 1 only.
//   - Then a port 0 read of addr 0x10 -> rdata = 0xDEAD_BEEF.
// - Reset mid-read: resetn low in the WAIT cycle -> no ack in any following cycle, outputs at reset values; next request serviced normally.
// - Held requests: req0 and req1 held high for 40 cycles -> acks alternate 0,1,0,1 every 4 cycles.
//   - With MEM_ARB_FIXED_PRIO_EN defined, only ack0 pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between port 0 (fetch) and port 1 (load/store).
// Default build is round-robin; define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req0,
   input  logic              rw0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rw,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic [1:0]        lat_q, lat_d;
   logic              ack0_q, ack0_d, ack1_q, ack1_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_rw_q, mem_rw_d;
   logic              pick1;
`ifndef MEM_ARB_FIXED_PRIO_EN
   logic              last_q, last_d;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (req0 || req1) state_d = S_ACCESS;
         S_ACCESS: state_d = mem_rw_q ? S_WAIT : S_RESP;
         S_WAIT:   if (lat_q == 2'd0) state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pick1       = 1'b0;
      gnt_d       = gnt_q;
      lat_d       = lat_q;
      rdata_d     = rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rw_d    = mem_rw_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_d      = last_q;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            pick1 = req1 && !req0;
`else
            // On a tie the port that was not served by the previous tie wins.
            pick1 = req1 && (!req0 || !last_q);
            if (req0 && req1) last_d = pick1;
`endif
            if (req0 || req1) begin
               gnt_d       = pick1;
               mem_addr_d  = pick1 ? addr1  : addr0;
               mem_wdata_d = pick1 ? wdata1 : wdata0;
               mem_rw_d    = pick1 ? rw1    : rw0;
            end
         end
         S_ACCESS: begin
            if (mem_rw_q) lat_d = 2'(READ_LAT - 1);
            else          mem_rw_d = 1'b1;
         end
         S_WAIT: begin
            if (lat_q != 2'd0) lat_d = lat_q - 2'd1;
            else               rdata_d = mem_rdata;
         end
         default: ;
      endcase
      ack0_d = (state_d == S_RESP) && !gnt_q;
      ack1_d = (state_d == S_RESP) &&  gnt_q;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         gnt_q       <= 1'b0;
         lat_q       <= 2'd0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         busy_q      <= 1'b0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rw_q    <= 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_q      <= 1'b1;
`endif
      end else begin
         gnt_q       <= gnt_d;
         lat_q       <= lat_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         busy_q      <= busy_d;
         rdata_q     <= rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rw_q    <= mem_rw_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_q      <= last_d;
`endif
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign busy      = busy_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rw    = mem_rw_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a READ_LAT=1 memory holding mem[i] = 0x1000_0000 + i.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req0, rw0, req1, rw1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        ack0, ack1, busy, mem_rw;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] mem [0:63];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .resetn(resetn),
      .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
      .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
      .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
      .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
      end else if (!mem_rw) begin
         mem[mem_addr[7:2]] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr[7:2]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      req0 = 0; rw0 = 1; addr0 = 0; wdata0 = 0;
      req1 = 0; rw1 = 1; addr1 = 0; wdata1 = 0;
      mem_rdata = 0;
      tick(); tick();
      chk("rst_ack0", 32'(ack0), 0);
      chk("rst_ack1", 32'(ack1), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_rw", 32'(mem_rw), 1);
      resetn = 1'b1;
      tick();
      chk("idle_mem_rw", 32'(mem_rw), 1);

      // Single read on port 0: ack at cycle 3, busy in cycles 1-3.
      req0 = 1; rw0 = 1; addr0 = 32'h08;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk($sformatf("rd_ack0_c%0d", c), 32'(ack0), 32'(c == 3));
         chk($sformatf("rd_ack1_c%0d", c), 32'(ack1), 0);
         chk($sformatf("rd_busy_c%0d", c), 32'(busy), 32'(c <= 3));
         if (c == 1) chk("rd_mem_addr", mem_addr, 32'h08);
         if (c == 3) begin
            chk("rd_rdata", rdata, 32'h1000_0002);
            req0 = 0;
         end
      end

      // Tie: port 0 first (last reset to 1).
      req0 = 1; rw0 = 1; addr0 = 32'h00;
      req1 = 1; rw1 = 1; addr1 = 32'h04;
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk($sformatf("tie1_ack0_c%0d", c), 32'(ack0), 32'(c == 3));
         chk($sformatf("tie1_ack1_c%0d", c), 32'(ack1), 32'(c == 7));
         if (c == 3) begin chk("tie1_rdata0", rdata, 32'h1000_0000); req0 = 0; end
         if (c == 7) begin chk("tie1_rdata1", rdata, 32'h1000_0001); req1 = 0; end
      end

      // Repeated tie: port 1 first.
      req0 = 1; req1 = 1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         chk($sformatf("tie2_ack1_c%0d", c), 32'(ack1), 32'(c == 3));
         chk($sformatf("tie2_ack0_c%0d", c), 32'(ack0), 32'(c == 7));
         if (c == 3) begin chk("tie2_rdata1", rdata, 32'h1000_0001); req1 = 0; end
         if (c == 7) begin chk("tie2_rdata0", rdata, 32'h1000_0000); req0 = 0; end
      end

      // Port 1 write: mem_rw low in cycle 1 only, ack at cycle 2, rdata untouched.
      req1 = 1; rw1 = 0; addr1 = 32'h10; wdata1 = 32'hDEAD_BEEF;
      chk("wr_mem_rw_c0", 32'(mem_rw), 1);
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk($sformatf("wr_mem_rw_c%0d", c), 32'(mem_rw), 32'(c != 1));
         chk($sformatf("wr_ack1_c%0d", c), 32'(ack1), 32'(c == 2));
         chk($sformatf("wr_ack0_c%0d", c), 32'(ack0), 0);
         if (c == 1) chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
         if (c == 2) begin chk("wr_rdata_hold", rdata, 32'h1000_0000); req1 = 0; rw1 = 1; end
      end

      // Port 0 reads back the written word.
      req0 = 1; rw0 = 1; addr0 = 32'h10;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk($sformatf("rb_ack0_c%0d", c), 32'(ack0), 32'(c == 3));
         if (c == 3) begin chk("rb_rdata", rdata, 32'hDEAD_BEEF); req0 = 0; end
      end

      // Reset sampled in the WAIT cycle abandons the read.
      req0 = 1; rw0 = 1; addr0 = 32'h0C;
      tick(); tick();
      chk("mr_busy_wait", 32'(busy), 1);
      resetn = 0; req0 = 0;
      tick();
      chk("mr_ack0", 32'(ack0), 0);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_mem_rw", 32'(mem_rw), 1);
      chk("mr_mem_addr", mem_addr, 0);
      chk("mr_rdata", rdata, 0);
      resetn = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("mr_noack0_%0d", c), 32'(ack0), 0);
         chk($sformatf("mr_noack1_%0d", c), 32'(ack1), 0);
      end

      // Next request after reset is serviced normally.
      req1 = 1; rw1 = 1; addr1 = 32'h14;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk($sformatf("pr_ack1_c%0d", c), 32'(ack1), 32'(c == 3));
         if (c == 3) begin chk("pr_rdata", rdata, 32'h1000_0005); req1 = 0; end
      end

      // Both ports held for 40 cycles.
      req0 = 1; rw0 = 1; addr0 = 32'h00;
      req1 = 1; rw1 = 1; addr1 = 32'h04;
      for (int c = 1; c <= 40; c++) begin
         tick();
`ifdef MEM_ARB_FIXED_PRIO_EN
         chk($sformatf("held_ack0_c%0d", c), 32'(ack0), 32'(c % 4 == 3));
         chk($sformatf("held_ack1_c%0d", c), 32'(ack1), 0);
`else
         chk($sformatf("held_ack0_c%0d", c), 32'(ack0), 32'(c % 8 == 3));
         chk($sformatf("held_ack1_c%0d", c), 32'(ack1), 32'(c % 8 == 7));
         if (c % 8 == 7) chk($sformatf("held_rdata1_c%0d", c), rdata, 32'h1000_0001);
`endif
         if (c % 8 == 3) chk($sformatf("held_rdata0_c%0d", c), rdata, 32'h1000_0000);
      end
      req0 = 0; req1 = 0;
      tick(); tick();
      chk("end_busy", 32'(busy), 0);
      chk("end_ack0", 32'(ack0), 0);
      chk("end_ack1", 32'(ack1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
